// File: rtl/bcd_countdown.sv
// Parametrised packed-BCD countdown timer with IDLE/RUN/EXPIRED control FSM.
// Optional macro MINSEC_EN: digit 1 counts 0..5 so DIGITS=4 gives mm:ss.
module bcd_countdown #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writeEnable,
  input  logic                  decrementEnable,
  input  logic                  start,
  input  logic                  pause,
  input  logic [4*DIGITS-1:0]   inputTime,
  output logic [4*DIGITS-1:0]   outputTime,
  output logic                  isZero,
  output logic                  done,
  output logic                  running
);

  localparam int unsigned W = 4 * DIGITS;

`ifdef MINSEC_EN
  localparam logic [3:0] DIGIT1_MAX = 4'd5;
`else
  localparam logic [3:0] DIGIT1_MAX = 4'd9;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   count, count_n;
  logic           done_n;

  function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   d;
    r = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (d > 4'd9) d = 4'd9;
      if (i == 1 && d > DIGIT1_MAX) d = DIGIT1_MAX;
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  // Ripple borrow from digit 0 upward; a zero digit wraps to its radix maximum.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   d;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          d = (i == 1) ? DIGIT1_MAX : 4'd9;
        end else begin
          d      = d - 4'd1;
          borrow = 1'b0;
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  always_comb begin
    state_n = state;
    count_n = count;
    done_n  = 1'b0;
    if (writeEnable) begin
      count_n = sanitize(inputTime);
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!pause && start && (count != '0)) state_n = RUN;
        end
        RUN: begin
          if (pause) begin
            state_n = IDLE;
          end else if (start) begin
            state_n = RUN;
          end else if (decrementEnable) begin
            count_n = bcd_dec(count);
            if (count_n == '0) begin
              state_n = EXPIRED;
              done_n  = 1'b1;
            end
          end
        end
        EXPIRED: begin
          count_n = '0;
        end
        default: begin
          state_n = IDLE;
          count_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      done       <= 1'b0;
      isZero     <= 1'b1;
      running    <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      done       <= done_n;
      isZero     <= (count_n == '0);
      running    <= (state_n == RUN);
    end
  end

  assign outputTime = count;

endmodule

// File: tb/tb_bcd_countdown.sv
// Self-checking bench for bcd_countdown: directed vector table plus randomized
// stimulus checked against a mixed-radix integer reference model.
module tb_bcd_countdown;

  localparam int unsigned D = 4;

`ifdef MINSEC_EN
  localparam bit MS = 1'b1;
`else
  localparam bit MS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, writeEnable, decrementEnable, start, pause;
  logic [15:0]   inputTime;
  logic [15:0]   outputTime;
  logic          isZero, done, running;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_countdown #(.DIGITS(D)) dut (
    .clk(clk), .reset(reset), .writeEnable(writeEnable),
    .decrementEnable(decrementEnable), .start(start), .pause(pause),
    .inputTime(inputTime), .outputTime(outputTime), .isZero(isZero),
    .done(done), .running(running)
  );

  typedef struct {
    logic        rst, we, dec, st, pa;
    logic [15:0] din;
    logic [15:0] e_time;
    logic        e_zero, e_done, e_run;
  } vec_t;

  vec_t vecs[$];

  // Reference model: count held as an integer in a mixed-radix number system.
  int  m_val;
  bit  m_run, m_exp, m_done;

  function automatic int radix(int unsigned i);
    return (MS && i == 1) ? 6 : 10;
  endfunction

  function automatic int load_value(logic [15:0] v);
    int r = 0;
    int d;
    for (int i = D - 1; i >= 0; i--) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      if (MS && i == 1 && d > 5) d = 5;
      r = r * radix(i) + d;
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r = '0;
    int x = v;
    for (int unsigned i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % radix(i));
      x = x / radix(i);
    end
    return r;
  endfunction

  task automatic model_step(input logic rst, we, dec, st, pa, input logic [15:0] din);
    if (rst) begin
      m_val = 0; m_run = 0; m_exp = 0; m_done = 0;
    end else if (we) begin
      m_val = load_value(din); m_run = 0; m_exp = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_exp) begin
      end else if (m_run) begin
        if (pa) m_run = 0;
        else if (!st && dec && m_val > 0) begin
          m_val = m_val - 1;
          if (m_val == 0) begin
            m_run = 0; m_exp = 1; m_done = 1;
          end
        end
      end else if (!pa && st && m_val != 0) begin
        m_run = 1;
      end
    end
  endtask

  task automatic check(input string name, input int idx, input logic [15:0] act, exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s #%0d: got %h, expected %h", name, idx, act, exp_v);
    end
  endtask

  task automatic cycle(input logic rst, we, dec, st, pa, input logic [15:0] din);
    reset = rst; writeEnable = we; decrementEnable = dec; start = st; pause = pa;
    inputTime = din;
    @(posedge clk);
    #1;
    model_step(rst, we, dec, st, pa, din);
  endtask

  task automatic add(input logic rst, we, dec, st, pa, input logic [15:0] din,
                     input logic [15:0] t, input logic z, dn, r);
    vec_t v;
    v.rst = rst; v.we = we; v.dec = dec; v.st = st; v.pa = pa; v.din = din;
    v.e_time = t; v.e_zero = z; v.e_done = dn; v.e_run = r;
    vecs.push_back(v);
  endtask

  initial begin
    logic [15:0] t099, t999, t0af;
    t099 = MS ? 16'h0059 : 16'h0099;
    t999 = MS ? 16'h0959 : 16'h0999;
    t0af = MS ? 16'h0059 : 16'h0099;

    //   rst we dec st pa  din       time     z  d  r
    add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0); // reset
    add(0, 1, 0, 0, 0, 16'h00AF, t0af,     0, 0, 0); // sanitised load
    add(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 1, 0, 0); // start at zero ignored
    add(0, 1, 0, 0, 0, 16'h0100, 16'h0100, 0, 0, 0);
    add(0, 0, 1, 1, 0, 16'h0000, 16'h0100, 0, 0, 1); // tick with start ignored
    add(0, 0, 1, 0, 0, 16'h0000, t099,     0, 0, 1); // borrow chain
    add(0, 1, 0, 0, 0, 16'h1000, 16'h1000, 0, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0000, 16'h1000, 0, 0, 1);
    add(0, 0, 1, 0, 0, 16'h0000, t999,     0, 0, 1);
    add(0, 1, 0, 0, 0, 16'h0002, 16'h0002, 0, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0000, 16'h0002, 0, 0, 1);
    add(0, 0, 1, 0, 0, 16'h0000, 16'h0001, 0, 0, 1);
    add(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 1, 0); // expiry pulse
    for (int i = 0; i < 5; i++)
      add(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 1, 0, 0); // start ignored in EXPIRED
    add(0, 0, 1, 0, 1, 16'h0000, 16'h0000, 1, 0, 0);
    add(0, 1, 0, 0, 0, 16'h0030, 16'h0030, 0, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0000, 16'h0030, 0, 0, 1);
    add(0, 0, 1, 0, 1, 16'h0000, 16'h0030, 0, 0, 0); // pause drops tick
    add(0, 0, 0, 1, 0, 16'h0000, 16'h0030, 0, 0, 1);
    add(0, 0, 1, 0, 0, 16'h0000, 16'h0029, 0, 0, 1);
    add(0, 1, 1, 1, 0, 16'h0015, 16'h0015, 0, 0, 0); // load wins over start+tick
    add(0, 0, 0, 0, 0, 16'h0000, 16'h0015, 0, 0, 0);
    add(0, 1, 0, 0, 0, 16'h0042, 16'h0042, 0, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0000, 16'h0042, 0, 0, 1);
    add(0, 0, 1, 0, 0, 16'h0000, 16'h0041, 0, 0, 1);
    add(0, 0, 1, 0, 0, 16'h0000, 16'h0040, 0, 0, 1);
    add(0, 0, 1, 0, 0, 16'h0000, 16'h0039, 0, 0, 1);
    add(1, 0, 1, 1, 0, 16'h0000, 16'h0000, 1, 0, 0); // reset mid-run
    add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);

    reset = 1'b1; writeEnable = 1'b0; decrementEnable = 1'b0;
    start = 1'b0; pause = 1'b0; inputTime = '0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].we, vecs[i].dec, vecs[i].st, vecs[i].pa, vecs[i].din);
      check("vec.time",    i, outputTime,     vecs[i].e_time);
      check("vec.isZero",  i, 16'(isZero),    16'(vecs[i].e_zero));
      check("vec.done",    i, 16'(done),      16'(vecs[i].e_done));
      check("vec.running", i, 16'(running),   16'(vecs[i].e_run));
    end

    for (int n = 0; n < 3000; n++) begin
      logic r, w, dc, s, p;
      logic [15:0] din;
      r  = ($urandom_range(199) == 0);
      w  = ($urandom_range(39) == 0);
      dc = ($urandom_range(2) != 0);
      s  = ($urandom_range(9) == 0);
      p  = ($urandom_range(19) == 0);
      din = 16'($urandom);
      if ($urandom_range(3) == 0) din[15:8] = 8'h00;
      if ($urandom_range(5) == 0) din[15:4] = 12'h000;
      cycle(r, w, dc, s, p, din);
      check("rnd.time",    n, outputTime,   to_bcd(m_val));
      check("rnd.isZero",  n, 16'(isZero),  16'(m_val == 0));
      check("rnd.done",    n, 16'(done),    16'(m_done));
      check("rnd.running", n, 16'(running), 16'(m_run));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
